instruction_prefetch_buffer: RTL and testbench



---
 rtl/pat_ibuf_pkg.sv | 23 ++
 rtl/ibuf_line_fifo.sv | 62 ++++++
 rtl/instruction_prefetch_buffer.sv | 134 +++++++++++++
 tb/tb_instruction_prefetch_buffer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pat_ibuf_pkg.sv
// Shared types and width helpers for the PAT instruction prefetch buffer.
package pat_ibuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ibuf_state_e;

  // Offset width; kept at least 1 so a one-word line still has a legal field.
  function automatic int off_w(input int fetch_words);
    return (fetch_words > 1) ? $clog2(fetch_words) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int line_w(input int fetch_words, input int i_width);
    return fetch_words * i_width;
  endfunction

endpackage

// File: rtl/ibuf_line_fifo.sv
// Line storage for the prefetch buffer: circular queue with count,
// flush, and push+pop in the same cycle even when full.
module ibuf_line_fifo
  import pat_ibuf_pkg::*;
#(
  parameter int LINE_W = 40,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [LINE_W-1:0] push_data,
  input  logic              pop,
  output logic [LINE_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop) && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data array needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Line-based instruction prefetch queue between the PAT core and instruction memory.
// Optional IBUF_BYPASS_EN: forwards mem_rdata to the core in the ack cycle when the queue is empty.
module instruction_prefetch_buffer
  import pat_ibuf_pkg::*;
#(
  parameter int i_width     = 20,
  parameter int i_adr_width = 10,
  parameter int fetch_words = 2,
  parameter int depth       = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       jump,
  input  logic [i_adr_width-1:0]                     pc,
  input  logic                                       instr_take,
  output logic [i_width-1:0]                         instruction,
  output logic                                       instr_valid,
  output logic [i_adr_width-1:0]                     instr_pc,
  output logic                                       mem_req,
  output logic [i_adr_width-$clog2(fetch_words)-1:0] mem_adr,
  input  logic                                       mem_ack,
  input  logic [fetch_words*i_width-1:0]             mem_rdata
);

  localparam int LOG_FW = $clog2(fetch_words);
  localparam int OFF_W  = off_w(fetch_words);
  localparam int LA_W   = i_adr_width - LOG_FW;
  localparam int LINE_W = line_w(fetch_words, i_width);

  ibuf_state_e             state_q, state_d;
  logic [LA_W-1:0]         line_q, line_d, req_adr_q, req_adr_d;
  logic [OFF_W-1:0]        rd_off_q, rd_off_d;
  logic [i_adr_width-1:0]  pc_q, pc_d;

  logic [LINE_W-1:0]       head, cur_line;
  logic                    fifo_empty, fifo_full;
  logic                    push, pop, flush;
  logic                    bypass, take_ok, last_word, ack_fill;

  ibuf_line_fifo #(.LINE_W(LINE_W), .DEPTH(depth)) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .flush    (flush),
    .push     (push),
    .push_data(mem_rdata),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; an ack always closes the transaction, even alongside a jump.
  always_comb begin
    state_d   = state_q;
    req_adr_d = req_adr_q;
    case (state_q)
      IDLE: if (!jump && !fifo_full) begin
        state_d   = WAIT;
        req_adr_d = line_q;
      end
      WAIT: if (mem_ack)   state_d = IDLE;
            else if (jump) state_d = DROP;
      DROP: if (mem_ack)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_req = (state_q != IDLE);
    mem_adr = req_adr_q;
  end

  always_comb begin
    bypass = 1'b0;
`ifdef IBUF_BYPASS_EN
    bypass = fifo_empty && (state_q == WAIT) && mem_ack && !jump;
`endif
    instr_valid = !fifo_empty || bypass;
    cur_line    = bypass ? mem_rdata : head;
    instruction = instr_valid ? cur_line[rd_off_q*i_width +: i_width] : '0;
    instr_pc    = pc_q;
  end

  always_comb begin
    take_ok   = instr_take && instr_valid && !jump;
    last_word = (rd_off_q == OFF_W'(fetch_words - 1));
    ack_fill  = (state_q == WAIT) && mem_ack && !jump;
    flush     = jump;
    pop       = 1'b0;
    // A bypassed line whose last word is taken now never needs storing.
    push      = ack_fill && !(bypass && take_ok && last_word);
    line_d    = line_q;
    rd_off_d  = rd_off_q;
    pc_d      = pc_q;
    if (jump) begin
      line_d   = LA_W'(pc >> LOG_FW);
      rd_off_d = OFF_W'(pc & i_adr_width'(fetch_words - 1));
      pc_d     = pc;
    end else begin
      if (ack_fill) line_d = line_q + 1'b1;
      if (take_ok) begin
        pc_d = pc_q + 1'b1;
        if (last_word) begin
          rd_off_d = '0;
          pop      = !fifo_empty;
        end else begin
          rd_off_d = rd_off_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q    <= '0;
      req_adr_q <= '0;
      rd_off_q  <= '0;
      pc_q      <= '0;
    end else begin
      line_q    <= line_d;
      req_adr_q <= req_adr_d;
      rd_off_q  <= rd_off_d;
      pc_q      <= pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Scoreboard bench for instruction_prefetch_buffer with a latency-programmable memory model.
module tb_instruction_prefetch_buffer;

  localparam int IW  = 20;
  localparam int AW  = 10;
  localparam int FW  = 2;
  localparam int LAW = 9;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             jump = 1'b0;
  logic [AW-1:0]    pc = '0;
  logic             instr_take = 1'b0;
  logic [IW-1:0]    instruction;
  logic             instr_valid;
  logic [AW-1:0]    instr_pc;
  logic             mem_req;
  logic [LAW-1:0]   mem_adr;
  logic             mem_ack = 1'b0;
  logic [FW*IW-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sb[$];
  int req_log[$];
  int mem_lat = 2;
  bit mem_hold = 1'b0;
  bit mem_force = 1'b0;

  instruction_prefetch_buffer dut (
    .clk(clk), .reset(reset), .jump(jump), .pc(pc), .instr_take(instr_take),
    .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Word k of line n holds its own word address n*FW+k.
  function automatic logic [FW*IW-1:0] line_data(input int adr);
    logic [FW*IW-1:0] r;
    for (int k = 0; k < FW; k++) r[k*IW +: IW] = IW'(adr * FW + k);
    return r;
  endfunction

  // Memory: logs each new request, acks mem_lat cycles later for one cycle.
  initial begin : memory
    int  cnt;
    bit  pend;
    int  cur;
    pend = 0; cnt = 0; cur = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (reset) begin
        pend = 0;
      end else if (mem_req) begin
        if (!pend) begin
          pend = 1; cnt = 0; cur = int'(mem_adr);
          req_log.push_back(cur);
        end else cnt++;
        if (mem_force || (!mem_hold && cnt >= mem_lat)) begin
          mem_ack = 1'b1;
          mem_rdata = line_data(cur);
          pend = 0;
          mem_force = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every accepted instruction must match the next expected address.
  always @(negedge clk) begin : monitor
    int e;
    if (!reset && instr_valid && instr_take && !jump) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: consumed instr=%h pc=%h with nothing expected", instruction, instr_pc);
      end else begin
        e = sb.pop_front();
        if (instruction !== IW'(e) || instr_pc !== AW'(e)) begin
          errors++;
          $display("FAIL sb_stream: got instr=%h pc=%h, expected instr=%h pc=%h",
                   instruction, instr_pc, IW'(e), AW'(e));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; jump = 1'b0; instr_take = 1'b0;
    mem_hold = 1'b0; mem_force = 1'b0; mem_lat = 2;
    sb.delete();
    @(posedge clk); #2 req_log.delete();
    @(posedge clk); #2 reset = 1'b0;
  endtask

  // Keep taking until the scoreboard drains, then stop before the next edge.
  task automatic drain(input string name, input int bound);
    instr_take = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    instr_take = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected words left, required 0", name, sb.size());
    end
  endtask

  task automatic wait_req(input int n, input int bound);
    bit found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(posedge clk); #2;
      if (req_log.size() >= n && mem_req && !mem_ack) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_req_timeout: %0d requests seen, required %0d", req_log.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #2;
    checks += 5;
    if (mem_req !== 1'b0)     begin errors++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    if (instruction !== '0)   begin errors++; $display("FAIL rst_instr: got %h, required 0", instruction); end
    if (instr_pc !== '0)      begin errors++; $display("FAIL rst_pc: got %h, required 0", instr_pc); end
    if (mem_adr !== '0)       begin errors++; $display("FAIL rst_mem_adr: got %h, required 0", mem_adr); end
  endtask

  task automatic test_fill();
    int ack_cyc = -1, val_cyc = -1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_ack && ack_cyc < 0) ack_cyc = cyc;
      if (instr_valid && val_cyc < 0) val_cyc = cyc;
    end
    checks += 5;
    if (val_cyc != ack_cyc + (BYP ? 0 : 1)) begin
      errors++; $display("FAIL fill_latency: valid at %0d, first ack at %0d", val_cyc, ack_cyc);
    end
    if (req_log.size() != 4) begin
      errors++; $display("FAIL fill_req_count: got %0d requests, required 4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (req_log[i] != i) begin errors++; $display("FAIL fill_adr: req %0d got %h, required %h", i, req_log[i], i); end
      end
    end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_full_req: got %b, required 0", mem_req); end
    if (instr_valid !== 1'b1 || instr_pc !== '0) begin
      errors++; $display("FAIL fill_head: valid=%b pc=%h, required 1/0", instr_valid, instr_pc);
    end
    if (instruction !== '0) begin errors++; $display("FAIL fill_instr: got %h, required 0", instruction); end
  endtask

  task automatic test_stream();
    int gaps = 0;
    mem_lat = 0;
    for (int a = 0; a < 40; a++) sb.push_back(a);
    instr_take = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
      if (!instr_valid) gaps++;
    end
    instr_take = 1'b0;
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL stream_timeout: %0d left, required 0", sb.size()); end
    if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d bubbles, required 0", gaps); end
  endtask

  task automatic test_jump_drop();
    do_reset();
    mem_lat = 6;
    for (int a = 0; a < 10; a++) sb.push_back(a);
    instr_take = 1'b1;
    wait_req(6, 300);
    instr_take = 1'b0;
    sb.delete();
    jump = 1'b1; pc = 10'h155;
    @(posedge clk); #2 jump = 1'b0;
    checks += 2;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL drop_req_held: got %b, required 1", mem_req); end
    if (mem_adr !== 9'h005) begin errors++; $display("FAIL drop_adr_held: got %h, required 005", mem_adr); end
    for (int a = 'h155; a < 'h15D; a++) sb.push_back(a);
    drain("drop", 400);
    checks++;
    if (req_log.size() < 8 || req_log[6] != 'hAA || req_log[7] != 'hAB) begin
      errors++; $display("FAIL drop_next_adr: %0d requests, required 0AA then 0AB after 005", req_log.size());
    end
  endtask

  task automatic test_jump_ack();
    int mark;
    do_reset();
    mem_hold = 1'b1;
    wait_req(1, 50);
    @(negedge clk) mem_force = 1'b1;
    @(posedge clk); #2;
    jump = 1'b1; pc = 10'h020;
    @(posedge clk); #2 jump = 1'b0;
    mark = req_log.size();
    mem_hold = 1'b0; mem_lat = 1;
    for (int a = 'h20; a < 'h28; a++) sb.push_back(a);
    drain("jack", 200);
    checks++;
    if (req_log.size() < mark + 2 || req_log[mark] != 'h10 || req_log[mark+1] != 'h11) begin
      errors++; $display("FAIL jack_reqs: %0d requests after jump, required 010 then 011", req_log.size() - mark);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_hold = 1'b1;
    wait_req(1, 50);
    jump = 1'b1; pc = 10'h3FE;
    @(posedge clk); #2 jump = 1'b0;
    mem_hold = 1'b0; mem_lat = 1;
    sb.push_back('h3FE); sb.push_back('h3FF);
    for (int a = 0; a < 4; a++) sb.push_back(a);
    drain("wrap", 200);
    checks++;
    if (req_log.size() < 3 || req_log[1] != 'h1FF || req_log[2] != 'h000) begin
      errors++; $display("FAIL wrap_adr: %0d requests, required 1FF then 000 after the dropped one", req_log.size());
    end
  endtask

  task automatic test_bypass();
    bit done = 0;
    do_reset();
    mem_hold = 1'b1;
    wait_req(1, 50);
    jump = 1'b1; pc = 10'h00B;
    @(posedge clk); #2 jump = 1'b0;
    mem_hold = 1'b0; mem_lat = 2;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (mem_ack && mem_adr == 9'h000) begin
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL byp_drop_valid: got %b, required 0", instr_valid); end
      end else if (mem_ack && mem_adr == 9'h005) begin
        checks += 2;
        if (instr_valid !== BYP) begin errors++; $display("FAIL byp_ack_valid: got %b, required %b", instr_valid, BYP); end
        if (instruction !== (BYP ? IW'('h00B) : '0)) begin
          errors++; $display("FAIL byp_ack_instr: got %h", instruction);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instruction !== IW'('h00B) || instr_pc !== 10'h00B) begin
          errors++; $display("FAIL byp_next: valid=%b instr=%h pc=%h, required 1/0000b/00b", instr_valid, instruction, instr_pc);
        end
        done = 1;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL byp_timeout: no ack for line 005, required one"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_lat = 3;
    wait_req(3, 100);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b, required 1", instr_valid); end
    reset = 1'b1;
    #1;
    checks += 3;
    if (mem_req !== 1'b0)     begin errors++; $display("FAIL rmid_req: got %b, required 0", mem_req); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, required 0", instr_valid); end
    if (instruction !== '0)   begin errors++; $display("FAIL rmid_instr: got %h, required 0", instruction); end
    @(posedge clk); #2 req_log.delete();
    reset = 1'b0;
    wait_req(1, 20);
    checks += 2;
    if (req_log.size() < 1 || req_log[0] != 0) begin errors++; $display("FAIL rmid_restart: first request not line 000"); end
    if (instr_pc !== '0) begin errors++; $display("FAIL rmid_pc: got %h, required 0", instr_pc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_jump_drop();
    test_jump_ack();
    test_wrap();
    test_bypass();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
